// File: rtl/qspi_driver_if.sv
// Command/response and QSPI pin bundle for qspi_driver.
// The driver takes the slave modport; the command issuer uses master.
interface qspi_driver_if;
  logic [4:0]  I_cmd_type;
  logic [7:0]  I_flash_cmd;
  logic [23:0] I_flash_addr;
  logic [15:0] I_status_reg;
  logic [7:0]  I_test_vec;
  logic        O_done_sig;
  logic [7:0]  O_read_data;
  logic        O_qspi_clk;
  logic        O_qspi_cs;
  logic [3:0]  O_qspi_io;
  logic [3:0]  O_qspi_io_oe;
  logic [3:0]  I_qspi_io;

  modport slave (
    input  I_cmd_type, I_flash_cmd, I_flash_addr, I_status_reg, I_test_vec, I_qspi_io,
    output O_done_sig, O_read_data, O_qspi_clk, O_qspi_cs, O_qspi_io, O_qspi_io_oe
  );

  modport master (
    output I_cmd_type, I_flash_cmd, I_flash_addr, I_status_reg, I_test_vec, I_qspi_io,
    input  O_done_sig, O_read_data, O_qspi_clk, O_qspi_cs, O_qspi_io, O_qspi_io_oe
  );
endinterface

// File: rtl/qspi_driver.sv
// QSPI flash command sequencer: mode-0 serial clock at clk_25M/2, single-line
// opcode/address/data frames, single-byte reads on IO1 and a quad program nibble phase.
module qspi_driver (
  input  logic         clk_25M,
  input  logic         I_rst_n,
  qspi_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  localparam logic [3:0] IO_IDLE   = 4'b1100;
  localparam logic [3:0] OE_SINGLE = 4'b1101;
  localparam logic [3:0] OE_QUAD   = 4'b1111;

  // Frame length in serial bits; zero marks an unsupported operation code.
  function automatic logic [5:0] frame_len(input logic [3:0] code);
    case (code)
      4'd1:    frame_len = 6'd8;
      4'd3:    frame_len = 6'd16;
      4'd5:    frame_len = 6'd40;
      4'd6:    frame_len = 6'd24;
      4'd8:    frame_len = 6'd34;
      default: frame_len = 6'd0;
    endcase
  endfunction

  state_t      state_reg;
  logic [3:0]  code_reg;
  logic [7:0]  cmd_reg;
  logic [23:0] addr_reg;
  logic [15:0] status_word_reg;
  logic [7:0]  vec_reg;
  logic [5:0]  bit_cnt_reg;
  logic        phase_b_reg;
  logic [7:0]  rx_reg;

  logic        done_reg;
  logic [7:0]  read_data_reg;
  logic        sclk_reg;
  logic        cs_reg;
  logic [3:0]  io_reg;
  logic [3:0]  oe_reg;

  logic [5:0]  len;
  logic        last_bit;
  logic        is_read;
  logic [5:0]  next_idx;
  logic [5:0]  ser_pos;
  logic        ser_bit;
  logic        quad_next;
  logic [3:0]  quad_nibble;
  logic [39:0] frame_bits;
  logic [7:0]  rx_next;
  logic [3:0]  lane_next;
  logic [3:0]  oe_next;

  assign len       = frame_len(code_reg);
  assign last_bit  = (bit_cnt_reg == len - 6'd1);
  assign next_idx  = bit_cnt_reg + 6'd1;
  assign is_read   = ((code_reg == 4'd3) || (code_reg == 4'd5)) && (bit_cnt_reg >= len - 6'd8);
  assign rx_next   = is_read ? {rx_reg[6:0], bus.I_qspi_io[1]} : rx_reg;

  // Everything a frame shifts out on IO0, MSB first; read phases shift zeros.
  always_comb begin
    frame_bits = {cmd_reg, 32'h0};
    case (code_reg)
      4'd5, 4'd8: frame_bits = {cmd_reg, addr_reg, 8'h00};
      4'd6:       frame_bits = {cmd_reg, status_word_reg, 16'h0000};
      default:    frame_bits = {cmd_reg, 32'h0};
    endcase
  end

  assign ser_pos     = 6'd39 - next_idx;
  assign ser_bit     = (next_idx < 6'd40) ? frame_bits[ser_pos] : 1'b0;
  assign quad_next   = (code_reg == 4'd8) && (next_idx >= 6'd32);
  assign quad_nibble = (next_idx == 6'd32) ? vec_reg[7:4] : vec_reg[3:0];
  assign oe_next     = quad_next ? OE_QUAD : OE_SINGLE;

  // Lane 0 carries serial data, lanes 2/3 hold WP#/HOLD# high, lane 1 is the input.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      if (gi == 0) begin : g_data
        assign lane_next[gi] = quad_next ? quad_nibble[gi] : ser_bit;
      end else begin : g_fixed
        assign lane_next[gi] = quad_next ? quad_nibble[gi] : IO_IDLE[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk_25M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_reg       <= IDLE;
      code_reg        <= 4'h0;
      cmd_reg         <= 8'h00;
      addr_reg        <= 24'h000000;
      status_word_reg <= 16'h0000;
      vec_reg         <= 8'h00;
      bit_cnt_reg     <= 6'd0;
      phase_b_reg     <= 1'b0;
      rx_reg          <= 8'h00;
      done_reg        <= 1'b0;
      read_data_reg   <= 8'h00;
      sclk_reg        <= 1'b0;
      cs_reg          <= 1'b1;
      io_reg          <= IO_IDLE;
      oe_reg          <= OE_SINGLE;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.I_cmd_type[4]) begin
            code_reg        <= bus.I_cmd_type[3:0];
            cmd_reg         <= bus.I_flash_cmd;
            addr_reg        <= bus.I_flash_addr;
            status_word_reg <= bus.I_status_reg;
            vec_reg         <= bus.I_test_vec;
            bit_cnt_reg     <= 6'd0;
            phase_b_reg     <= 1'b0;
            rx_reg          <= 8'h00;
            if (frame_len(bus.I_cmd_type[3:0]) != 6'd0) begin
              // Every supported frame opens with the opcode MSB in phase A.
              state_reg <= SHIFT;
              cs_reg    <= 1'b0;
              io_reg    <= {IO_IDLE[3:1], bus.I_flash_cmd[7]};
              oe_reg    <= OE_SINGLE;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (!phase_b_reg) begin
            sclk_reg    <= 1'b1;
            phase_b_reg <= 1'b1;
          end else begin
            sclk_reg    <= 1'b0;
            phase_b_reg <= 1'b0;
            rx_reg      <= rx_next;
            if (last_bit) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              cs_reg    <= 1'b1;
              io_reg    <= IO_IDLE;
              oe_reg    <= OE_SINGLE;
              if ((code_reg == 4'd3) || (code_reg == 4'd5))
                read_data_reg <= rx_next;
            end else begin
              bit_cnt_reg <= next_idx;
              io_reg      <= lane_next;
              oe_reg      <= oe_next;
            end
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= GAP;
        end

        GAP: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.O_done_sig   = done_reg;
  assign bus.O_read_data  = read_data_reg;
  assign bus.O_qspi_clk   = sclk_reg;
  assign bus.O_qspi_cs    = cs_reg;
  assign bus.O_qspi_io    = io_reg;
  assign bus.O_qspi_io_oe = oe_reg;

endmodule

// File: tb/tb_qspi_driver.sv
// Directed bench for qspi_driver: a small flash model answers reads on IO1 and
// a per-frame monitor captures CS, clock pulses, serial bits and quad nibbles.
module tb_qspi_driver;

  logic clk_25M = 1'b0;
  logic I_rst_n = 1'b0;
  always #20 clk_25M = ~clk_25M;

  qspi_driver_if bus();

  qspi_driver dut (
    .clk_25M (clk_25M),
    .I_rst_n (I_rst_n),
    .bus     (bus)
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Flash model: returns flash_byte MSB first on IO1 starting at serial bit rd_start.
  logic [7:0] flash_byte = 8'h00;
  int         rd_start   = 99;
  int         sclk_cnt   = 0;
  int         fl_idx;

  always @(posedge bus.O_qspi_clk or posedge bus.O_qspi_cs) begin
    if (bus.O_qspi_cs) sclk_cnt <= 0;
    else               sclk_cnt <= sclk_cnt + 1;
  end

  always_comb begin
    bus.I_qspi_io = 4'b0000;
    fl_idx = sclk_cnt - 1 - rd_start;
    if (sclk_cnt > 0 && fl_idx >= 0 && fl_idx < 8)
      bus.I_qspi_io[1] = flash_byte[7 - fl_idx];
  end

  // Results of the most recent watched frame.
  int          cs_low, pulses, nsb, nquad, done_cyc, bad;
  logic [39:0] sbits;
  logic [7:0]  quad, rd_at_done;

  task automatic issue(input logic [3:0] code, input logic [7:0] cmd, input logic [23:0] addr,
                       input logic [15:0] st, input logic [7:0] vec, input bit hold);
    bus.I_cmd_type   = {1'b1, code};
    bus.I_flash_cmd  = cmd;
    bus.I_flash_addr = addr;
    bus.I_status_reg = st;
    bus.I_test_vec   = vec;
    @(posedge clk_25M); #1;
    if (!hold) begin
      // Scramble everything after acceptance; the frame must not notice.
      bus.I_cmd_type   = {1'b0, ~code};
      bus.I_flash_cmd  = ~cmd;
      bus.I_flash_addr = ~addr;
      bus.I_status_reg = ~st;
      bus.I_test_vec   = ~vec;
    end
  endtask

  // Call just after the accepting edge; cycle n is sampled on the n-th falling edge.
  task automatic watch(input int max_cyc);
    cs_low = 0; pulses = 0; nsb = 0; nquad = 0; done_cyc = 0; bad = 0;
    sbits = '0; quad = 8'h00; rd_at_done = 8'h00;
    for (int n = 1; n <= max_cyc && done_cyc == 0; n++) begin
      @(negedge clk_25M);
      if (bus.O_qspi_cs === 1'b0) begin
        cs_low++;
        if (!(bus.O_qspi_io_oe === 4'b1101 || bus.O_qspi_io_oe === 4'b1111)) bad++;
        if (bus.O_qspi_io_oe === 4'b1101 && bus.O_qspi_io[3:2] !== 2'b11) bad++;
        if (bus.O_done_sig !== 1'b0) bad++;
        if (bus.O_qspi_clk === 1'b1) begin
          pulses++;
          if (bus.O_qspi_io_oe === 4'b1111) begin
            quad = {quad[3:0], bus.O_qspi_io};
            nquad++;
          end else begin
            sbits = {sbits[38:0], bus.O_qspi_io[0]};
            nsb++;
          end
        end
      end else begin
        if (bus.O_qspi_clk !== 1'b0 || bus.O_qspi_io !== 4'b1100 || bus.O_qspi_io_oe !== 4'b1101) bad++;
      end
      if (bus.O_done_sig === 1'b1) begin
        done_cyc   = n;
        rd_at_done = bus.O_read_data;
      end
    end
    $display("frame: cs_low=%0d pulses=%0d single=%0d quad_nibbles=%0d done_cycle=%0d read=%02h pin_errs=%0d",
             cs_low, pulses, nsb, nquad, done_cyc, rd_at_done, bad);
  endtask

  task automatic idle_wait();
    repeat (3) @(posedge clk_25M);
    #1;
  endtask

  task automatic test_reset();
    bus.I_cmd_type   = 5'b1_0001;
    bus.I_flash_cmd  = 8'h06;
    bus.I_flash_addr = 24'h0;
    bus.I_status_reg = 16'h0;
    bus.I_test_vec   = 8'h0;
    repeat (2) @(posedge clk_25M);
    #1;
    check_cnt++; if (bus.O_qspi_cs !== 1'b1) $display("FAIL reset_cs got=%b want=1", bus.O_qspi_cs); else pass_cnt++;
    check_cnt++; if (bus.O_qspi_clk !== 1'b0) $display("FAIL reset_clk got=%b want=0", bus.O_qspi_clk); else pass_cnt++;
    check_cnt++; if (bus.O_qspi_io !== 4'b1100) $display("FAIL reset_io got=%b want=1100", bus.O_qspi_io); else pass_cnt++;
    check_cnt++; if (bus.O_qspi_io_oe !== 4'b1101) $display("FAIL reset_oe got=%b want=1101", bus.O_qspi_io_oe); else pass_cnt++;
    check_cnt++; if (bus.O_done_sig !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.O_done_sig); else pass_cnt++;
    check_cnt++; if (bus.O_read_data !== 8'h00) $display("FAIL reset_rdata got=%02h want=00", bus.O_read_data); else pass_cnt++;
    @(negedge clk_25M);
    I_rst_n = 1'b1;
    #1;
    check_cnt++; if (bus.O_qspi_cs !== 1'b1) $display("FAIL release_no_accept cs got=%b want=1", bus.O_qspi_cs); else pass_cnt++;
    @(posedge clk_25M); #1;
    bus.I_cmd_type = 5'b0_0000;
    watch(40);
    check_cnt++; if (done_cyc !== 17) $display("FAIL release_first_edge done_cycle got=%0d want=17", done_cyc); else pass_cnt++;
  endtask

  task automatic test_write_enable();
    idle_wait();
    rd_start = 99;
    issue(4'd1, 8'h06, 24'h0, 16'h0, 8'h0, 1'b0);
    watch(40);
    check_cnt++; if (cs_low !== 16) $display("FAIL wren_cs_low got=%0d want=16", cs_low); else pass_cnt++;
    check_cnt++; if (pulses !== 8) $display("FAIL wren_pulses got=%0d want=8", pulses); else pass_cnt++;
    check_cnt++; if (nsb !== 8 || sbits[7:0] !== 8'h06) $display("FAIL wren_bits got=%02h/%0d want=06/8", sbits[7:0], nsb); else pass_cnt++;
    check_cnt++; if (done_cyc !== 17) $display("FAIL wren_done got=%0d want=17", done_cyc); else pass_cnt++;
    check_cnt++; if (bad !== 0) $display("FAIL wren_pins got=%0d want=0", bad); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    idle_wait();
    rd_start   = 8;
    flash_byte = 8'h01;
    issue(4'd3, 8'h05, 24'h0, 16'h0, 8'h0, 1'b1);
    watch(60);
    check_cnt++; if (cs_low !== 32) $display("FAIL poll1_cs_low got=%0d want=32", cs_low); else pass_cnt++;
    check_cnt++; if (done_cyc !== 33) $display("FAIL poll1_done got=%0d want=33", done_cyc); else pass_cnt++;
    check_cnt++; if (rd_at_done !== 8'h01) $display("FAIL poll1_rdata got=%02h want=01", rd_at_done); else pass_cnt++;
    check_cnt++; if (nsb !== 16 || sbits[15:8] !== 8'h05) $display("FAIL poll1_opcode got=%02h want=05", sbits[15:8]); else pass_cnt++;
    flash_byte = 8'h00;
    @(negedge clk_25M);
    check_cnt++; if (bus.O_qspi_cs !== 1'b1) $display("FAIL poll_gap_cs got=%b want=1", bus.O_qspi_cs); else pass_cnt++;
    repeat (2) @(posedge clk_25M);
    #1;
    bus.I_cmd_type = 5'b0_0000;
    watch(60);
    check_cnt++; if (cs_low !== 32) $display("FAIL poll2_cs_low got=%0d want=32", cs_low); else pass_cnt++;
    check_cnt++; if (done_cyc !== 33) $display("FAIL poll2_done got=%0d want=33", done_cyc); else pass_cnt++;
    check_cnt++; if (rd_at_done !== 8'h00) $display("FAIL poll2_rdata got=%02h want=00", rd_at_done); else pass_cnt++;
    check_cnt++; if (sbits[15:8] !== 8'h05) $display("FAIL poll2_opcode got=%02h want=05", sbits[15:8]); else pass_cnt++;
  endtask

  task automatic test_quad_program();
    idle_wait();
    rd_start = 99;
    issue(4'd8, 8'h32, 24'h0000FF, 16'h0, 8'hA5, 1'b0);
    watch(100);
    check_cnt++; if (nsb !== 32 || sbits[31:0] !== 32'h320000FF) $display("FAIL quad_single got=%08h/%0d want=320000ff/32", sbits[31:0], nsb); else pass_cnt++;
    check_cnt++; if (nquad !== 2 || quad !== 8'hA5) $display("FAIL quad_nibbles got=%02h/%0d want=a5/2", quad, nquad); else pass_cnt++;
    check_cnt++; if (cs_low !== 68) $display("FAIL quad_cs_low got=%0d want=68", cs_low); else pass_cnt++;
    check_cnt++; if (done_cyc !== 69) $display("FAIL quad_done got=%0d want=69", done_cyc); else pass_cnt++;
    check_cnt++; if (bad !== 0) $display("FAIL quad_pins got=%0d want=0", bad); else pass_cnt++;
  endtask

  task automatic test_read_and_config();
    idle_wait();
    rd_start   = 32;
    flash_byte = 8'h3C;
    issue(4'd5, 8'h03, 24'h000010, 16'h0, 8'h0, 1'b0);
    watch(100);
    check_cnt++; if (cs_low !== 80) $display("FAIL read_cs_low got=%0d want=80", cs_low); else pass_cnt++;
    check_cnt++; if (done_cyc !== 81) $display("FAIL read_done got=%0d want=81", done_cyc); else pass_cnt++;
    check_cnt++; if (rd_at_done !== 8'h3C) $display("FAIL read_rdata got=%02h want=3c", rd_at_done); else pass_cnt++;
    check_cnt++; if (nsb !== 40 || sbits[39:8] !== 32'h03000010) $display("FAIL read_hdr got=%08h want=03000010", sbits[39:8]); else pass_cnt++;
    idle_wait();
    rd_start = 99;
    issue(4'd6, 8'hB1, 24'h0, 16'hAFE7, 8'h0, 1'b0);
    watch(80);
    check_cnt++; if (nsb !== 24 || sbits[23:0] !== 24'hB1AFE7) $display("FAIL cfg_bits got=%06h/%0d want=b1afe7/24", sbits[23:0], nsb); else pass_cnt++;
    check_cnt++; if (cs_low !== 48) $display("FAIL cfg_cs_low got=%0d want=48", cs_low); else pass_cnt++;
    check_cnt++; if (done_cyc !== 49) $display("FAIL cfg_done got=%0d want=49", done_cyc); else pass_cnt++;
    check_cnt++; if (rd_at_done !== 8'h3C) $display("FAIL cfg_rdata_hold got=%02h want=3c", rd_at_done); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int late_done;
    idle_wait();
    rd_start   = 32;
    flash_byte = 8'hC3;
    issue(4'd5, 8'h03, 24'h000020, 16'h0, 8'h0, 1'b0);
    repeat (20) @(negedge clk_25M);
    check_cnt++; if (bus.O_qspi_cs !== 1'b0) $display("FAIL midrst_pre_cs got=%b want=0", bus.O_qspi_cs); else pass_cnt++;
    I_rst_n = 1'b0;
    #1;
    check_cnt++; if (bus.O_qspi_cs !== 1'b1 || bus.O_qspi_clk !== 1'b0) $display("FAIL midrst_pins cs/clk got=%b%b want=10", bus.O_qspi_cs, bus.O_qspi_clk); else pass_cnt++;
    check_cnt++; if (bus.O_qspi_io !== 4'b1100 || bus.O_qspi_io_oe !== 4'b1101) $display("FAIL midrst_io got=%b/%b want=1100/1101", bus.O_qspi_io, bus.O_qspi_io_oe); else pass_cnt++;
    check_cnt++; if (bus.O_read_data !== 8'h00) $display("FAIL midrst_rdata got=%02h want=00", bus.O_read_data); else pass_cnt++;
    late_done = 0;
    repeat (3) begin
      @(negedge clk_25M);
      if (bus.O_done_sig !== 1'b0) late_done++;
    end
    check_cnt++; if (late_done !== 0) $display("FAIL midrst_no_done got=%0d want=0", late_done); else pass_cnt++;
    I_rst_n = 1'b1;
    @(posedge clk_25M); #1;
    rd_start = 99;
    issue(4'd1, 8'h04, 24'h0, 16'h0, 8'h0, 1'b0);
    watch(40);
    check_cnt++; if (done_cyc !== 17 || sbits[7:0] !== 8'h04) $display("FAIL midrst_recover got=%0d/%02h want=17/04", done_cyc, sbits[7:0]); else pass_cnt++;
  endtask

  task automatic test_unsupported();
    idle_wait();
    issue(4'd2, 8'h9F, 24'h123456, 16'h0, 8'h0, 1'b0);
    watch(10);
    check_cnt++; if (done_cyc !== 1) $display("FAIL unsup2_done got=%0d want=1", done_cyc); else pass_cnt++;
    check_cnt++; if (cs_low !== 0 || bad !== 0) $display("FAIL unsup2_pins got=%0d/%0d want=0/0", cs_low, bad); else pass_cnt++;
    check_cnt++; if (rd_at_done !== 8'h00) $display("FAIL unsup2_rdata got=%02h want=00", rd_at_done); else pass_cnt++;
    idle_wait();
    issue(4'hF, 8'hAB, 24'h0, 16'h0, 8'h0, 1'b0);
    watch(10);
    check_cnt++; if (done_cyc !== 1 || cs_low !== 0) $display("FAIL unsupF got=%0d/%0d want=1/0", done_cyc, cs_low); else pass_cnt++;
  endtask

  initial begin
    bus.I_cmd_type   = 5'b0;
    bus.I_flash_cmd  = 8'h0;
    bus.I_flash_addr = 24'h0;
    bus.I_status_reg = 16'h0;
    bus.I_test_vec   = 8'h0;
    test_reset();
    test_write_enable();
    test_back_to_back();
    test_quad_program();
    test_read_and_config();
    test_reset_mid_frame();
    test_unsupported();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/qspi_driver.md
QSPI_DRIVER -- requirements
Module: qspi_driver

Interface
REQ-001 SHALL have port clk_25M  input  1  sole clock, 25 MHz.
REQ-002 SHALL have port I_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port I_cmd_type  input  5  bit4 = request valid, bits3:0 = operation code.
REQ-004 SHALL have port I_flash_cmd  input  8  opcode byte sent to the flash.
REQ-005 SHALL have port I_flash_addr  input  24  flash byte address.
REQ-006 SHALL have port I_status_reg  input  16  nonvolatile config word to write.
REQ-007 SHALL have port I_test_vec  input  8  program data byte.
REQ-008 SHALL have port O_done_sig  output  1  one-cycle transaction-complete pulse.
REQ-009 SHALL have port O_read_data  output  8  last byte read from flash.
REQ-010 SHALL have port O_qspi_clk  output  1  serial clock, mode 0, idle low.
REQ-011 SHALL have port O_qspi_cs  output  1  chip select, active low.
REQ-012 SHALL have ports O_qspi_io / O_qspi_io_oe / I_qspi_io  output/output/input  4 each  IO0..IO3 drive value, drive enable, sampled value.

Function
REQ-013 SHALL use states IDLE, SHIFT, DONE, GAP.
REQ-014 IDLE: when I_cmd_type[4]=1, SHALL latch I_cmd_type[3:0], I_flash_cmd, I_flash_addr, I_status_reg and I_test_vec, then enter SHIFT; input changes after latching SHALL be ignored until IDLE.
REQ-015 Frames (bit counts are transferred bits):
- 1: opcode, 8 out.
- 3: opcode + 8 in.
- 5: opcode + addr + 8 in.
- 6: opcode + status_reg MSB first, 24 out.
- 8: opcode + addr single-line, then test_vec on 4 lines, 2 nibbles, high nibble first.
REQ-016 Any other code SHALL not assert CS; the FSM goes IDLE->DONE->GAP.
REQ-017 SHIFT: each serial-clock period SHALL be 2 clk cycles. Phase A: O_qspi_clk=0 and the next bit driven. Phase B: O_qspi_clk=1. Serial data is MSB first.
REQ-018 O_qspi_cs SHALL be low in exactly the SHIFT cycles: 2*P cycles, with P = 8/16/40/24/34 for codes 1/3/5/6/8.
REQ-019 Single-line phases SHALL drive IO0=data, IO2=1, IO3=1, O_qspi_io_oe=4'b1101, with IO1 as input.
REQ-020 Quad data phase SHALL drive O_qspi_io_oe=4'b1111 and O_qspi_io = nibble.
REQ-021 Read bits SHALL be taken from I_qspi_io[1] at the clk edge ending each phase-B cycle and shifted into a byte, MSB first.
REQ-022 DONE follows the last phase-B cycle. It SHALL last exactly 1 cycle with O_done_sig=1, O_qspi_cs=1 and O_qspi_clk=0. For codes 3 and 5, O_read_data SHALL update in the same cycle; otherwise it holds.
REQ-023 Completion latency: O_done_sig SHALL be high in cycle 2*P+1 after the accepting edge (cycle 1 after it for unsupported codes).
REQ-024 GAP SHALL last 1 cycle, ignore I_cmd_type, and then return to IDLE. This guarantees at least 2 CS-high cycles between frames and lets the issuer clear its request after the done pulse.
REQ-025 If I_cmd_type[4] is still 1 in IDLE after GAP, a new transaction SHALL start (status-poll reissue).
REQ-026 Outside SHIFT: O_qspi_cs=1, O_qspi_clk=0, O_qspi_io_oe=4'b1101, O_qspi_io=4'b1100.

Reset
REQ-027 While I_rst_n=0: state=IDLE, O_done_sig=0, O_read_data=8'h00, O_qspi_cs=1, O_qspi_clk=0, O_qspi_io=4'b1100, O_qspi_io_oe=4'b1101, all latches 0. This SHALL apply immediately, including mid-frame.
REQ-028 After reset release, the first request SHALL be accepted no earlier than the first rising edge with I_rst_n=1.

Verification
REQ-029 Code 1, opcode 8'h06 -> CS low 16 cycles, 8 clock pulses, IO0 = 0000_0110, done in cycle 17.
REQ-030 Code 3, opcode 8'h05, flash returns 8'h01 then 8'h00 while request held -> two frames, each 32 CS-low cycles, O_read_data 8'h01 then 8'h00.
REQ-031 Code 8, opcode 8'h32, addr 24'h0000FF, vec 8'hA5 -> 32 single-line bits, then IO[3:0]=4'hA then 4'h5 with oe=4'b1111, CS low 68 cycles.
REQ-032 Code 6, opcode 8'hB1, status 16'hAFE7 -> 24 bits B1 AF E7, done in cycle 49; code 5 at addr 24'h000010 returning 8'h3C -> O_read_data=8'h3C in cycle 81.
REQ-033 Reset asserted during cycle 20 of a code-5 frame -> CS high and clock low immediately, no done pulse, O_read_data=8'h00; the next request runs normally.
REQ-034 Code 4'h2 -> no CS activity, done in cycle 1; inputs changed mid-frame -> transmitted bits unchanged.
